// File: rtl/cgra_seq_pkg.sv
// cgra_seq_pkg: shared state encoding and default widths for the CGRA PC sequencer.
// Contents: seq_state_t (IDLE/FETCH/EXEC/VECT/FINISH), CGRA_PC_W, CGRA_VLEN_W,
// CGRA_BR_CNT_W. No ports.
package cgra_seq_pkg;

    localparam int CGRA_PC_W     = 12;
    localparam int CGRA_VLEN_W   = 16;
    localparam int CGRA_BR_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        VECT   = 3'd3,
        FINISH = 3'd4
    } seq_state_t;

endpackage

// File: rtl/cgra_elem_counter.sv
// cgra_elem_counter: vector element index register with last-element compare.
// Ports: clk, rst_n (async active-low); clear zeroes the index, step increments it;
// len is the element count; idx is the current index; last is high when idx == len-1.
module cgra_elem_counter
    import cgra_seq_pkg::*;
#(
    parameter int W = CGRA_VLEN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         step,
    input  logic [W-1:0] len,
    output logic [W-1:0] idx,
    output logic         last
);

    logic [W-1:0] idx_q, idx_d;

    assign idx_d = clear ? '0 : step ? idx_q + 1'b1 : idx_q;
    assign idx   = idx_q;
    // A zero length never has a last element; EXEC never enters VECT with it.
    assign last  = (len != '0) && (idx_q == len - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_d;
    end

endmodule

// File: rtl/cgra_pc_sequencer.sv
// cgra_pc_sequencer: program-counter and vector-element sequencer for one CGRA PE.
// Inputs : axis_aclk, axis_resetn (async active-low); start/abort control;
//          start_pc/end_pc program bounds; is_not_vect, is_bne, is_vstreamout,
//          is_halt, flag_neq, branch_imm, vect_len describe the instruction at pc;
//          done_steady datapath ready; supplier stream ownership; max_branches limit.
// Outputs: pc, busy, done, retire, elem_valid, elem_idx, done_auto_incr, err_loop.
// Option : define CGRA_LOOP_LIMIT_EN to count taken branches and flag err_loop when
//          the count reaches max_branches; otherwise err_loop is tied low.
module cgra_pc_sequencer
    import cgra_seq_pkg::*;
#(
    parameter int PC_W     = CGRA_PC_W,
    parameter int VLEN_W   = CGRA_VLEN_W,
    parameter int BR_CNT_W = CGRA_BR_CNT_W
) (
    input  logic                axis_aclk,
    input  logic                axis_resetn,
    input  logic                start,
    input  logic                abort,
    input  logic [PC_W-1:0]     start_pc,
    input  logic [PC_W-1:0]     end_pc,
    input  logic                is_not_vect,
    input  logic                is_bne,
    input  logic                is_vstreamout,
    input  logic                is_halt,
    input  logic                flag_neq,
    input  logic [PC_W-1:0]     branch_imm,
    input  logic [VLEN_W-1:0]   vect_len,
    input  logic                done_steady,
    input  logic                supplier,
    input  logic [BR_CNT_W-1:0] max_branches,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic                done,
    output logic                retire,
    output logic                elem_valid,
    output logic [VLEN_W-1:0]   elem_idx,
    output logic                done_auto_incr,
    output logic                err_loop
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_next;
    logic            done_q, retire_q, retire_d;
    logic            launch, exec_go, vect_go, taken, scalar_like, vect_hold, at_end;
    logic            limit_hit;
    logic            elem_clear, elem_step, elem_last;

    assign launch      = (state_q == IDLE) && start && !abort;
    assign exec_go     = (state_q == EXEC) && done_steady && !abort;
    assign vect_go     = (state_q == VECT) && done_steady && !abort;
    assign taken       = is_not_vect && is_bne && flag_neq && !is_halt;
    // Zero-length vectors retire like scalar non-branch instructions.
    assign scalar_like = is_not_vect || (vect_len == '0);
    assign vect_hold   = is_vstreamout && !supplier;
    assign at_end      = pc_q == end_pc;
    // Retiring end_pc keeps pc there; otherwise advance, wrapping modulo 2^PC_W.
    assign pc_next     = at_end ? pc_q : pc_q + 1'b1;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = start ? FETCH : IDLE;
                FETCH:   state_d = EXEC;
                EXEC:    if (done_steady)
                             state_d = is_halt     ? FINISH :
                                       taken       ? (limit_hit ? FINISH : FETCH) :
                                       scalar_like ? (at_end ? FINISH : FETCH) : VECT;
                VECT:    if (done_steady && elem_last && !vect_hold)
                             state_d = at_end ? FINISH : FETCH;
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d       = launch ? start_pc : pc_q;
        retire_d   = 1'b0;
        elem_clear = 1'b0;
        elem_step  = 1'b0;
        if (exec_go) begin
            retire_d   = is_halt || taken || scalar_like;
            elem_clear = !retire_d;
            if (taken && !limit_hit)                    pc_d = branch_imm;
            else if (!is_halt && !taken && scalar_like) pc_d = pc_next;
        end
        if (vect_go) begin
            elem_step = !elem_last;
            retire_d  = elem_last && !vect_hold;
            if (retire_d) pc_d = pc_next;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pc_q     <= '0;
            done_q   <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            done_q   <= state_d == FINISH;
            retire_q <= retire_d;
        end
    end

    cgra_elem_counter #(.W(VLEN_W)) u_elem (
        .clk   (axis_aclk),
        .rst_n (axis_resetn),
        .clear (elem_clear),
        .step  (elem_step),
        .len   (vect_len),
        .idx   (elem_idx),
        .last  (elem_last)
    );

`ifdef CGRA_LOOP_LIMIT_EN
    logic [BR_CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic                err_q, err_d;

    assign limit_hit = br_cnt_q == max_branches;

    always_comb begin
        br_cnt_d = br_cnt_q;
        err_d    = err_q;
        if (launch) begin
            br_cnt_d = '0;
            err_d    = 1'b0;
        end else if (exec_go && taken) begin
            err_d    = err_q | limit_hit;
            br_cnt_d = (limit_hit || &br_cnt_q) ? br_cnt_q : br_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            br_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            br_cnt_q <= br_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_loop = err_q;
`else
    logic [BR_CNT_W-1:0] unused_max_branches;

    assign unused_max_branches = max_branches;
    assign limit_hit           = 1'b0;
    assign err_loop            = 1'b0;
`endif

    assign pc             = pc_q;
    assign busy           = state_q != IDLE;
    assign done           = done_q;
    assign retire         = retire_q;
    assign done_auto_incr = (state_q == VECT) && elem_last;
    // A vstreamout at its last element without stream ownership does not step.
    assign elem_valid     = (state_q == VECT) && done_steady && !(elem_last && vect_hold);

endmodule

// File: tb/tb_cgra_pc_sequencer.sv
// tb_cgra_pc_sequencer: scoreboard bench; stimulus queues expected retire/done and element events, a negedge monitor pops and compares.
module tb_cgra_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, done_steady = 1'b1, supplier = 1'b1;
    logic        flag_neq;
    logic [11:0] start_pc = '0, end_pc = '0, branch_imm = '0;
    logic [15:0] vect_len, max_branches = 16'd2;
    logic        is_not_vect, is_bne, is_vstreamout, is_halt;
    logic [11:0] pc;
    logic        busy, done, retire, elem_valid, done_auto_incr, err_loop;
    logic [15:0] elem_idx;

    logic        p_nv[16], p_bne[16], p_vso[16], p_halt[16];
    logic [15:0] p_len[16];
    int          checks = 0, errors = 0, br_mode = 0, br_seen = 0, cyc;

    typedef struct { bit d; logic [11:0] pc; bit err; } ev_t;
    typedef struct { logic [15:0] idx; bit dai; } el_t;
    ev_t ev_q[$];
    el_t el_q[$];

    always #5 clk = ~clk;

    assign is_not_vect   = p_nv[pc[3:0]];
    assign is_bne        = p_bne[pc[3:0]];
    assign is_vstreamout = p_vso[pc[3:0]];
    assign is_halt       = p_halt[pc[3:0]];
    assign vect_len      = p_len[pc[3:0]];
    assign flag_neq      = (br_mode == 2) || (br_mode == 1 && br_seen < 2);

    cgra_pc_sequencer dut (
        .axis_aclk(clk), .axis_resetn(rst_n), .start(start), .abort(abort),
        .start_pc(start_pc), .end_pc(end_pc), .is_not_vect(is_not_vect), .is_bne(is_bne),
        .is_vstreamout(is_vstreamout), .is_halt(is_halt), .flag_neq(flag_neq),
        .branch_imm(branch_imm), .vect_len(vect_len), .done_steady(done_steady),
        .supplier(supplier), .max_branches(max_branches), .pc(pc), .busy(busy),
        .done(done), .retire(retire), .elem_valid(elem_valid), .elem_idx(elem_idx),
        .done_auto_incr(done_auto_incr), .err_loop(err_loop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        checks++;
        errors++;
        $display("FAIL unexpected_%s: got a pulse, expected none queued", name);
    endtask

    task automatic exp_r(input logic [11:0] p, input bit e = 1'b0);
        ev_q.push_back('{1'b0, p, e});
    endtask

    task automatic exp_d(input logic [11:0] p, input bit e = 1'b0);
        ev_q.push_back('{1'b1, p, e});
    endtask

    task automatic exp_e(input logic [15:0] i, input bit a);
        el_q.push_back('{i, a});
    endtask

    task automatic pop_ev(input bit d);
        ev_t e;
        if (ev_q.size() == 0) unexp(d ? "done" : "retire");
        else begin
            e = ev_q.pop_front();
            chk(d ? "event_kind_done" : "event_kind_retire", {31'd0, d}, {31'd0, e.d});
            chk(d ? "done_pc" : "retire_pc", {20'd0, pc}, {20'd0, e.pc});
            chk("event_err_loop", {31'd0, err_loop}, {31'd0, e.err});
        end
    endtask

    always @(negedge clk) begin
        if (retire) pop_ev(1'b0);
        if (done) pop_ev(1'b1);
        if (elem_valid) begin
            if (el_q.size() == 0) unexp("elem");
            else begin
                el_t e;
                e = el_q.pop_front();
                chk("elem_idx", {16'd0, elem_idx}, {16'd0, e.idx});
                chk("elem_done_auto_incr", {31'd0, done_auto_incr}, {31'd0, e.dai});
            end
        end
        if (br_mode == 1 && retire && pc == 12'd0) br_seen++;
    end

    task automatic clr_prog();
        for (int i = 0; i < 16; i++) begin
            p_nv[i] = 1'b1; p_bne[i] = 1'b0; p_vso[i] = 1'b0; p_halt[i] = 1'b0; p_len[i] = '0;
        end
    endtask

    task automatic kick(input logic [11:0] sp, input logic [11:0] ep);
        start_pc = sp;
        end_pc = ep;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("pc_at_start", {20'd0, pc}, {20'd0, sp});
    endtask

    task automatic run(input logic [11:0] sp, input logic [11:0] ep, output int n);
        kick(sp, ep);
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: done not seen after %0d cycles, required within 2000", n);
        end
        repeat (3) @(posedge clk);
        #1 chk("queues_drained", ev_q.size() + el_q.size(), 32'd0);
    endtask

    task automatic wait_vect_idx(input logic [15:0] i);
        int n = 0;
        while (!(elem_valid && elem_idx == i) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_elem_idx: elem_idx %0d never seen, required %0d", elem_idx, i);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required to finish");
        $fatal(1);
    end

    initial begin
        clr_prog();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", {20'd0, pc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_elem_valid", {31'd0, elem_valid}, 32'd0);
        chk("rst_elem_idx", {16'd0, elem_idx}, 32'd0);
        chk("rst_done_auto_incr", {31'd0, done_auto_incr}, 32'd0);
        chk("rst_err_loop", {31'd0, err_loop}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Scalar run 0..3: four retires, done 8 cycles after start.
        exp_r(1); exp_r(2); exp_r(3); exp_r(3); exp_d(3);
        run(0, 3, cyc);
        chk("scalar_done_latency", cyc, 32'd8);

        // bne at pc 2 taken twice then falls through.
        clr_prog();
        p_bne[2] = 1'b1;
        branch_imm = 12'd0;
        br_seen = 0;
        br_mode = 1;
        exp_r(1); exp_r(2); exp_r(0); exp_r(1); exp_r(2); exp_r(0);
        exp_r(1); exp_r(2); exp_r(3); exp_r(3); exp_d(3);
        run(0, 3, cyc);
        chk("branch_done_latency", cyc, 32'd20);
        br_mode = 0;

        // Vector of 4 at pc 1.
        clr_prog();
        p_nv[1] = 1'b0;
        p_len[1] = 16'd4;
        exp_r(1);
        exp_e(0, 0); exp_e(1, 0); exp_e(2, 0); exp_e(3, 1);
        exp_r(2); exp_r(2); exp_d(2);
        run(0, 2, cyc);
        chk("vector_done_latency", cyc, 32'd10);

        // vstreamout of 2 held 5 cycles at the last element without ownership.
        clr_prog();
        p_nv[0] = 1'b0;
        p_vso[0] = 1'b1;
        p_len[0] = 16'd2;
        supplier = 1'b0;
        exp_e(0, 0); exp_e(1, 1);
        exp_r(1); exp_r(1); exp_d(1);
        fork
            run(0, 1, cyc);
            begin
                int n = 0;
                while (!done_auto_incr && n < 200) begin
                    @(posedge clk);
                    #1 n++;
                end
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_pc", {20'd0, pc}, 32'd0);
                    chk("hold_elem_valid", {31'd0, elem_valid}, 32'd0);
                end
                @(posedge clk);
                #1 supplier = 1'b1;
                @(posedge clk);
                #1 chk("vso_retire_on_supplier", {31'd0, retire}, 32'd1);
            end
        join

        // done_steady low for 3 cycles mid-VECT.
        clr_prog();
        p_nv[0] = 1'b0;
        p_len[0] = 16'd4;
        exp_e(0, 0); exp_e(1, 0); exp_e(2, 0); exp_e(3, 1);
        exp_r(1); exp_r(1); exp_d(1);
        fork
            run(0, 1, cyc);
            begin
                wait_vect_idx(2);
                done_steady = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_elem_idx", {16'd0, elem_idx}, 32'd2);
                    chk("stall_elem_valid", {31'd0, elem_valid}, 32'd0);
                end
                @(posedge clk);
                #1 done_steady = 1'b1;
            end
        join

        // Zero-length vector behaves as scalar; halt at pc 1 ends before end_pc.
        clr_prog();
        p_nv[0] = 1'b0;
        p_halt[1] = 1'b1;
        exp_r(1); exp_r(1); exp_d(1);
        run(0, 5, cyc);
        chk("halt_done_latency", cyc, 32'd4);

        // pc wraps from all-ones to zero.
        clr_prog();
        exp_r(0); exp_r(0); exp_d(0);
        run(12'hFFF, 12'h000, cyc);
        chk("wrap_done_latency", cyc, 32'd4);

        // abort mid-program: IDLE next edge, pc held, no done.
        begin
            int n = 0, dn = 0;
            exp_r(1); exp_r(2);
            kick(0, 7);
            while (pc != 12'd2 && n < 200) begin
                @(posedge clk);
                #1 n++;
            end
            abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_pc_held", {20'd0, pc}, 32'd2);
            repeat (10) begin
                @(negedge clk);
                dn += int'(done);
            end
            chk("abort_no_done", dn, 32'd0);
            chk("abort_queues_drained", ev_q.size() + el_q.size(), 32'd0);
        end

        // start together with abort in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", {31'd0, busy}, 32'd0);
        chk("start_abort_pc", {20'd0, pc}, 32'd2);

        // Reset asserted mid-VECT clears outputs immediately.
        clr_prog();
        p_nv[0] = 1'b0;
        p_len[0] = 16'd8;
        exp_e(0, 0); exp_e(1, 0); exp_e(2, 0);
        kick(0, 1);
        wait_vect_idx(3);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", {20'd0, pc}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_elem_idx", {16'd0, elem_idx}, 32'd0);
        chk("mid_rst_elem_valid", {31'd0, elem_valid}, 32'd0);
        chk("mid_rst_done_auto_incr", {31'd0, done_auto_incr}, 32'd0);
        chk("mid_rst_retire", {31'd0, retire}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        chk("mid_rst_queues_drained", ev_q.size() + el_q.size(), 32'd0);

`ifdef CGRA_LOOP_LIMIT_EN
        // Infinite bne loop with limit 2: third taken branch flags err_loop.
        clr_prog();
        p_bne[1] = 1'b1;
        branch_imm = 12'd0;
        max_branches = 16'd2;
        br_mode = 2;
        exp_r(1); exp_r(0); exp_r(1); exp_r(0); exp_r(1); exp_r(1, 1'b1); exp_d(1, 1'b1);
        run(0, 5, cyc);
        chk("loop_err_sticky", {31'd0, err_loop}, 32'd1);
        br_mode = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cgra_pc_sequencer.md
# cgra_pc_sequencer

Program-counter sequencer for one CGRA processing element. It owns the PC register and the vector element counter. It steps scalar instructions, takes `bne` branches, repeats vector instructions over `vect_len` elements and gates `vstreamout` completion on supplier ownership. It sits between the instruction memory (address out, decoded fields back one cycle later) and the PE datapath, which signals `done_steady` when it can accept the next step.

## Interface
- `PC_W`, 12, PC and branch-target width
- `VLEN_W`, 16, vector length / element index width
- `BR_CNT_W`, 16, taken-branch counter width (used only with `CGRA_LOOP_LIMIT_EN`)

Ports:
- `axis_aclk`  in  1  clock
- `axis_resetn`  in  1  asynchronous active-low reset
- `start`  in  1  begin program at `start_pc`; ignored while `busy`
- `abort`  in  1  synchronous return to IDLE
- `start_pc`  in  PC_W  first instruction address
- `end_pc`  in  PC_W  last instruction address; retiring it ends the program
- `is_not_vect`  in  1  decoded: scalar instruction
- `is_bne`  in  1  decoded: branch-if-not-equal
- `is_vstreamout`  in  1  decoded: vector stream-out
- `is_halt`  in  1  decoded: halt
- `flag_neq`  in  1  comparison flag from datapath
- `branch_imm`  in  PC_W  absolute branch target
- `vect_len`  in  VLEN_W  element count of the current vector instruction
- `done_steady`  in  1  datapath ready to step
- `supplier`  in  1  this PE currently owns the stream output
- `max_branches`  in  BR_CNT_W  taken-branch limit (used only with the macro)
- `pc`  out  PC_W  instruction memory address
- `busy`  out  1  not in IDLE
- `done`  out  1  one-cycle end-of-program pulse
- `retire`  out  1  one-cycle pulse when an instruction completes
- `elem_valid`  out  1  element step taken this cycle
- `elem_idx`  out  VLEN_W  current element index
- `done_auto_incr`  out  1  high while `elem_idx == vect_len-1` in VECT
- `err_loop`  out  1  sticky branch-limit error

## Operation
- States: IDLE, FETCH, EXEC, VECT, FINISH.
- IDLE:
  - `start` → `pc<=start_pc`, go to FETCH; clears `err_loop` and the branch count.
- FETCH:
  - One cycle for instruction memory latency, then EXEC.
  - Decoded inputs are valid only in EXEC and VECT.
- EXEC (waits while `done_steady=0`):
  - `is_halt` → retire, go to FINISH.
  - Scalar `bne` with `flag_neq` → `pc<=branch_imm`, retire, go to FETCH.
  - Other scalar → retire, then:
    - if `pc==end_pc`, go to FINISH;
    - else `pc<=pc+1`, go to FETCH.
  - Vector with `vect_len==0` → treated as scalar non-branch (retire, advance).
  - Vector with `vect_len>0` → `elem_idx<=0`, go to VECT.
- VECT (per cycle with `done_steady=1`):
  - `elem_valid=1`.
  - If `elem_idx<vect_len-1`, increment `elem_idx`.
  - At the last element (`done_auto_incr=1`):
    - a non-vstreamout instruction retires and advances as a scalar non-branch;
    - a `vstreamout` instruction retires only when `supplier=1`; otherwise it holds at the last element with `elem_valid=0` until `supplier` rises.
- FINISH: `done=1` for one cycle, then IDLE.
- PC arithmetic is modulo 2^PC_W: `pc+1` at all-ones wraps to 0. A branch target beyond `end_pc` is legal.
- `abort` in any state → IDLE on the next edge. `pc`, `elem_idx` and `err_loop` are held; no `done` pulse.
- `start` together with `abort` in IDLE: `abort` wins.

## Timing
- Reset values:
  - `pc=0`, `busy=0`, `done=0`, `retire=0`, `elem_valid=0`, `elem_idx=0`, `done_auto_incr=0`, `err_loop=0`, state IDLE.
- All outputs are registered except:
  - `busy`, a decode of the state;
  - `done_auto_incr` and `elem_valid`, combinational from state, `elem_idx`, `vect_len`, `done_steady`, `supplier`.
- Scalar instruction: minimum 2 cycles (FETCH + EXEC).
- Vector instruction: minimum 2 + `vect_len` cycles.
- `start` → first `pc` at the IDLE→FETCH edge; `busy` is high the cycle after `start`.
- `done_steady=0` stalls all state, `pc` and `elem_idx` with no side effects.

## Configuration
- `CGRA_LOOP_LIMIT_EN` defined:
  - Each taken branch increments a saturating BR_CNT_W counter.
  - A branch taken when count `== max_branches` sets `err_loop` instead and goes to FINISH.
  - A `max_branches` of 0 means any taken branch sets `err_loop`.
- Undefined:
  - No counter; `err_loop` is tied 0; `max_branches` is unused.

## Structure
- Package `cgra_seq_pkg`: state enum `seq_state_t`, default widths `CGRA_PC_W=12` and `CGRA_VLEN_W=16`.
- Sub-module `cgra_elem_counter`:
  - inputs `clear` and `step`, plus `len`;
  - outputs `idx` and `last`;
  - owns the `elem_idx` register and the last-element compare.

## Test plan
- Scalar run: `start_pc=0`, `end_pc=3`, all scalar, `done_steady=1` → `pc` steps 0,1,2,3; 4 `retire` pulses; `done` 8 cycles after `start`.
- Branch: `bne` at pc 2 with `branch_imm=0`, `flag_neq=1` twice then 0 → `pc` sequence 0,1,2,0,1,2,0,1,2,3; `done` pulses.
- Vector: `vect_len=4` at pc 1 → `elem_idx` 0..3; `done_auto_incr` only when `elem_idx=3`; `pc` then 2.
- vstreamout: `vect_len=2`, `supplier=0` for 5 cycles at the last element → `pc` holds, `elem_valid=0` during the hold; `retire` on the first cycle with `supplier=1`.
- Stall and abort:
  - `done_steady=0` mid-VECT for 3 cycles → `elem_idx` frozen;
  - `abort` → IDLE next cycle, no `done` pulse;
  - `axis_resetn` low mid-VECT → all reset values immediately.
- With `CGRA_LOOP_LIMIT_EN`: `max_branches=2`, infinite `bne` loop → third taken branch sets `err_loop=1` and `done` pulses.
